// File: rtl/parity_serial_tx.sv
// Serial parity transmitter: accepts a word via valid/ready and sends it LSB-first, then one parity bit.
// Optional macro PARITY_ERR_INJECT_EN adds err_inject, which inverts the parity bit of the captured frame.
module parity_serial_tx #(
  parameter int unsigned DATA_W     = 8,
  parameter bit          ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
`ifdef PARITY_ERR_INJECT_EN
  input  logic              err_inject,
`endif
  output logic              din_ready,
  output logic              x,
  output logic              frame,
  output logic              par_bit,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  state_t            state;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              par_acc;
  logic              inj_q;
  logic              accept;

  assign accept    = din_valid && din_ready;
  assign shift_nxt = shift_reg >> 1;

`ifdef PARITY_ERR_INJECT_EN
  always_ff @(posedge clk) begin
    if (rst)         inj_q <= 1'b0;
    else if (accept) inj_q <= err_inject;
  end
`else
  assign inj_q = 1'b0;
`endif

  // x is registered, so each transition loads the value the next cycle must show.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      cnt       <= '0;
      par_acc   <= 1'b0;
      x         <= 1'b0;
      frame     <= 1'b0;
      par_bit   <= 1'b0;
      busy      <= 1'b0;
      din_ready <= 1'b1;
    end else begin
      case (state)
        IDLE, PARITY: begin
          if (accept) begin
            state     <= DATA;
            shift_reg <= din;
            cnt       <= '0;
            par_acc   <= ODD_PARITY;
            x         <= din[0];
            frame     <= 1'b1;
            par_bit   <= 1'b0;
            busy      <= 1'b1;
            din_ready <= 1'b0;
          end else begin
            state     <= IDLE;
            x         <= 1'b0;
            frame     <= 1'b0;
            par_bit   <= 1'b0;
            busy      <= 1'b0;
            din_ready <= 1'b1;
          end
        end
        DATA: begin
          shift_reg <= shift_nxt;
          par_acc   <= par_acc ^ shift_reg[0];
          cnt       <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) begin
            state     <= PARITY;
            x         <= par_acc ^ shift_reg[0] ^ inj_q;
            par_bit   <= 1'b1;
            din_ready <= 1'b1;
          end else begin
            x <= shift_nxt[0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Randomized self-checking bench for parity_serial_tx: even and odd instances against a frame-queue model.
module tb_parity_serial_tx;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         err_inject = 1'b0;
  logic         ready_e, x_e, frame_e, par_e, busy_e;
  logic         ready_o, x_o, frame_o, par_o, busy_o;

  always #5 clk = ~clk;

  parity_serial_tx #(.DATA_W(W), .ODD_PARITY(1'b0)) dut_e (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
`ifdef PARITY_ERR_INJECT_EN
    .err_inject(err_inject),
`endif
    .din_ready(ready_e), .x(x_e), .frame(frame_e), .par_bit(par_e), .busy(busy_e)
  );

  parity_serial_tx #(.DATA_W(W), .ODD_PARITY(1'b1)) dut_o (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
`ifdef PARITY_ERR_INJECT_EN
    .err_inject(err_inject),
`endif
    .din_ready(ready_o), .x(x_o), .frame(frame_o), .par_bit(par_o), .busy(busy_o)
  );

  typedef struct packed {logic x; logic frame; logic par; logic inj;} sym_t;

  sym_t q_e[$];
  sym_t q_o[$];
  sym_t cur_e = '0;
  sym_t cur_o = '0;
  bit   model_on = 1'b0;
  bit   acc = 1'b0;
  logic inj_eff;
  logic det = 1'b0;
  logic par_hist_e[$];
  logic par_hist_o[$];
  int   run = 0;
  int   max_run = 0;
  int   n_tests = 0;
  int   n_fail = 0;

`ifdef PARITY_ERR_INJECT_EN
  assign inj_eff = err_inject;
`else
  assign inj_eff = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: each accepted word expands into its full list of line symbols.
  always @(posedge clk) begin
    if (rst) begin
      q_e.delete();
      q_o.delete();
      cur_e    = '0;
      cur_o    = '0;
      acc      = 1'b0;
      model_on = 1'b1;
    end else if (model_on) begin
      acc = din_valid && (!cur_e.frame || cur_e.par);
      if (acc) begin
        for (int i = 0; i < W; i++) begin
          q_e.push_back(sym_t'{x: din[i], frame: 1'b1, par: 1'b0, inj: 1'b0});
          q_o.push_back(sym_t'{x: din[i], frame: 1'b1, par: 1'b0, inj: 1'b0});
        end
        q_e.push_back(sym_t'{x: (^din) ^ inj_eff, frame: 1'b1, par: 1'b1, inj: inj_eff});
        q_o.push_back(sym_t'{x: ~(^din) ^ inj_eff, frame: 1'b1, par: 1'b1, inj: inj_eff});
      end
      cur_e = (q_e.size() > 0) ? q_e.pop_front() : '0;
      cur_o = (q_o.size() > 0) ? q_o.pop_front() : '0;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("even_line", {27'd0, x_e, frame_e, par_e, busy_e, ready_e},
            {27'd0, cur_e.x, cur_e.frame, cur_e.par, cur_e.frame, !(cur_e.frame && !cur_e.par)});
      check("odd_line", {27'd0, x_o, frame_o, par_o, busy_o, ready_o},
            {27'd0, cur_o.x, cur_o.frame, cur_o.par, cur_o.frame, !(cur_o.frame && !cur_o.par)});
      if (!cur_e.frame) det = 1'b0;
      else det = det ^ x_e;
      if (cur_e.par) begin
        check("detector_z", {31'd0, det}, {31'd0, cur_e.inj});
        det = 1'b0;
      end
      if (par_e) par_hist_e.push_back(x_e);
      if (par_o) par_hist_o.push_back(x_o);
      if (frame_e) run++;
      else begin
        if (run > max_run) max_run = run;
        run = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [W-1:0] d, input logic inj);
    int k;
    din        = d;
    din_valid  = 1'b1;
    err_inject = inj;
    k = 0;
    do begin
      step();
      k++;
    end while (!acc && k < 40);
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    din_valid = 1'b0;
    din       = W'($urandom);
    err_inject = 1'($urandom);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (cur_e.frame && k < 40) begin
      step();
      k++;
    end
    if (cur_e.frame) check("idle_timeout", 32'd0, 32'd1);
    step();
  endtask

  task automatic check_par(input string tag, input logic pe, input logic po);
    check({tag, "_even_par"}, {31'd0, (par_hist_e.size() > 0) ? par_hist_e[0] : 1'bx}, {31'd0, pe});
    check({tag, "_odd_par"},  {31'd0, (par_hist_o.size() > 0) ? par_hist_o[0] : 1'bx}, {31'd0, po});
    par_hist_e.delete();
    par_hist_o.delete();
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (10) step();
    check("idle_no_parity", par_hist_e.size(), 32'd0);

    send(8'hA5, 1'b0); wait_idle(); check_par("a5", 1'b0, 1'b1);
    send(8'h07, 1'b0); wait_idle(); check_par("07", 1'b1, 1'b0);
    send(8'h00, 1'b0); wait_idle(); check_par("00", 1'b0, 1'b1);

    max_run = 0;
    send(8'hFF, 1'b0);
    send(8'h01, 1'b0);
    wait_idle();
    check("b2b_run", max_run, 32'd18);
    check("b2b_count", par_hist_e.size(), 32'd2);
    if (par_hist_e.size() == 2) begin
      check("b2b_par0", {31'd0, par_hist_e[0]}, 32'd0);
      check("b2b_par1", {31'd0, par_hist_e[1]}, 32'd1);
    end
    par_hist_e.delete();
    par_hist_o.delete();

    send(8'hC3, 1'b0);
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_frame", {31'd0, frame_e}, 32'd0);
    check("abort_ready", {31'd0, ready_e}, 32'd1);
    repeat (12) step();
    check("abort_no_parity", par_hist_e.size(), 32'd0);
    send(8'h81, 1'b0); wait_idle(); check_par("81", 1'b0, 1'b1);

`ifdef PARITY_ERR_INJECT_EN
    send(8'h3C, 1'b1); wait_idle(); check_par("3c_inj", 1'b1, 1'b0);
    send(8'h3C, 1'b0); wait_idle(); check_par("3c_clean", 1'b0, 1'b1);
`endif

    for (int c = 0; c < 600; c++) begin
      din        = W'($urandom);
      din_valid  = 1'($urandom);
      err_inject = ($urandom_range(0, 7) == 0);
      rst        = ($urandom_range(0, 99) == 0);
      step();
    end
    rst       = 1'b0;
    din_valid = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
